// File: rtl/dcm_pkg.sv
// dcm_pkg: definitions shared by the DCM measurement blocks.
//   state_t          responder handshake / measurement state
//   TDL_WIDTH_DEF    default number of delay-line taps per snapshot
//   LOG2_AVG_DEF     default log2 of snapshots averaged per measurement
//   POP_W_DEF        popcount width for the default tap count
//   pop_width()      popcount width for an arbitrary tap count
package dcm_pkg;

  localparam int TDL_WIDTH_DEF = 20;
  localparam int LOG2_AVG_DEF  = 3;

  // A popcount of w bits ranges 0..w, so it needs clog2(w+1) bits.
  function automatic int pop_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int POP_W_DEF = $clog2(TDL_WIDTH_DEF + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    MEAS = 3'd2,
    CONV = 3'd3,
    DONE = 3'd4,
    REL  = 3'd5
  } state_t;

endpackage

// File: rtl/dcm_popcount.sv
// dcm_popcount: purely combinational population count of a TDL snapshot.
//   WIDTH   parameter, number of taps
//   bits    input  [WIDTH-1:0]            snapshot
//   count   output [clog2(WIDTH+1)-1:0]   number of ones in bits
module dcm_popcount #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0]             bits,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int POP_W = $clog2(WIDTH + 1);

  // Running partial sums; partial[i] holds the ones in bits[i-1:0].
  logic [POP_W-1:0] partial [WIDTH+1];

  assign partial[0] = '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
    assign partial[gi+1] = partial[gi] + POP_W'(bits[gi]);
  end

  assign count = partial[WIDTH];

endmodule

// File: rtl/dcm_responder.sv
// dcm_responder: measurement side of the controller/DCM request-ready-finish
// handshake. Averages 2^LOG2_AVG snapshots of the selected TDL phase and
// returns the half-up rounded average as a thermometer code.
//   clk_in    clock, rising edge
//   rstn      synchronous active-low reset
//   request   start a measurement (taken only in IDLE)
//   pos_neg   phase select latched with request: 0 = tap_pos, 1 = tap_neg
//   finish    controller has consumed theta
//   tap_pos   high-phase snapshot, one per cycle
//   tap_neg   low-phase snapshot, one per cycle
//   theta     averaged thermometer code, held until the next conversion
//   ready     result valid (state DONE)
//   meas_sel  latched phase select of the current transaction
module dcm_responder
  import dcm_pkg::*;
#(
  parameter int TDL_WIDTH = TDL_WIDTH_DEF,
  parameter int LOG2_AVG  = LOG2_AVG_DEF
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 request,
  input  logic                 pos_neg,
  input  logic                 finish,
  input  logic [TDL_WIDTH-1:0] tap_pos,
  input  logic [TDL_WIDTH-1:0] tap_neg,
  output logic [TDL_WIDTH-1:0] theta,
  output logic                 ready,
  output logic                 meas_sel
);

  localparam int POP_W = pop_width(TDL_WIDTH);
  localparam int ACC_W = POP_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] NUM_SAMPLES = CNT_W'(2 ** LOG2_AVG);
  localparam logic [ACC_W-1:0] HALF        = ACC_W'(2 ** (LOG2_AVG - 1));

  state_t                 state_reg, state_next;
  logic [TDL_WIDTH-1:0]   snap_reg;
  logic [ACC_W-1:0]       acc_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   meas_sel_reg;
  logic [TDL_WIDTH-1:0]   theta_reg;

  logic [POP_W-1:0]       pop_count;
  logic [ACC_W-1:0]       rounded;
  logic [POP_W-1:0]       avg;
  logic [TDL_WIDTH-1:0]   therm_next;

  dcm_popcount #(.WIDTH(TDL_WIDTH)) u_popcount (
    .bits  (snap_reg),
    .count (pop_count)
  );

  // acc <= 2^LOG2_AVG * TDL_WIDTH, so adding half an LSB still fits in ACC_W.
  assign rounded = acc_reg + HALF;
  assign avg     = POP_W'(rounded >> LOG2_AVG);

  for (genvar gi = 0; gi < TDL_WIDTH; gi++) begin : g_therm
    assign therm_next[gi] = (avg > POP_W'(gi));
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (request)               state_next = ARM;
      ARM:     if (!request)              state_next = MEAS;
      // One extra MEAS cycle after the last addition lets the final sum settle.
      MEAS:    if (cnt_reg == NUM_SAMPLES) state_next = CONV;
      CONV:                               state_next = DONE;
      DONE:    if (finish)                state_next = REL;
      REL:     if (!finish)               state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = 1'b0;
    if (state_reg == DONE) begin
      ready = 1'b1;
    end
  end

  assign theta    = theta_reg;
  assign meas_sel = meas_sel_reg;

  // Datapath: snapshot, accumulator, sample counter, result register.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      snap_reg     <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      meas_sel_reg <= 1'b0;
      theta_reg    <= '0;
    end else begin
      // The snapshot loads every cycle; the one captured on ARM->MEAS is the first summed.
      snap_reg <= meas_sel_reg ? tap_neg : tap_pos;

      if (state_reg == IDLE && request) begin
        meas_sel_reg <= pos_neg;
      end

      if (state_reg == ARM && !request) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (state_reg == MEAS && cnt_reg != NUM_SAMPLES) begin
        acc_reg <= acc_reg + ACC_W'(pop_count);
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      if (state_reg == CONV) begin
        theta_reg <= therm_next;
      end
    end
  end

endmodule

// File: tb/tb_dcm_responder.sv
module tb_dcm_responder;

  localparam int W = 20;
  localparam int N = 8;

  logic         clk_in  = 1'b0;
  logic         rstn    = 1'b0;
  logic         request = 1'b0;
  logic         pos_neg = 1'b0;
  logic         finish  = 1'b0;
  logic [W-1:0] tap_pos = '0;
  logic [W-1:0] tap_neg = '0;
  logic [W-1:0] theta;
  logic         ready;
  logic         meas_sel;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] samp [N];
  logic         cur_pn;

  dcm_responder #(.TDL_WIDTH(W), .LOG2_AVG(3)) dut (
    .clk_in   (clk_in),
    .rstn     (rstn),
    .request  (request),
    .pos_neg  (pos_neg),
    .finish   (finish),
    .tap_pos  (tap_pos),
    .tap_neg  (tap_neg),
    .theta    (theta),
    .ready    (ready),
    .meas_sel (meas_sel)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference: mean of the ones counts, rounded half-up, as a thermometer code.
  function automatic logic [W-1:0] model_theta();
    int sum;
    int avg;
    sum = 0;
    for (int i = 0; i < N; i++) sum += $countones(samp[i]);
    avg = (sum + N / 2) / N;
    return W'((1 << avg) - 1);
  endfunction

  task automatic drive_sample(input int k);
    if (cur_pn) begin
      tap_neg = samp[k];
      tap_pos = W'($urandom);
    end else begin
      tap_pos = samp[k];
      tap_neg = W'($urandom);
    end
  endtask

  task automatic drive_junk();
    tap_pos = W'($urandom);
    tap_neg = W'($urandom);
  endtask

  // Runs request/measurement until ready rises; lat = edges after the edge E.
  task automatic do_measure(input logic pn, input int req_cycles, output int lat,
                            output logic early, output logic [W-1:0] th, output logic ms);
    cur_pn = pn;
    early  = 1'b0;
    @(negedge clk_in);
    request = 1'b1;
    pos_neg = pn;
    for (int i = 0; i < req_cycles; i++) begin
      @(negedge clk_in);
      pos_neg = 1'($urandom);
    end
    request = 1'b0;
    drive_sample(0);
    for (int k = 1; k < N; k++) begin
      @(negedge clk_in);
      if (ready) early = 1'b1;
      drive_sample(k);
    end
    lat = 6;
    while (lat < 40) begin
      @(negedge clk_in);
      lat++;
      drive_junk();
      if (ready) break;
    end
    th = theta;
    ms = meas_sel;
  endtask

  task automatic do_finish(input int wait_cycles, input int hold, output logic stable,
                           output logic rdy_after, output logic [W-1:0] th_after);
    logic [W-1:0] th0;
    th0    = theta;
    stable = 1'b1;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk_in);
      drive_junk();
      if (!ready || theta !== th0) stable = 1'b0;
    end
    finish = 1'b1;
    @(negedge clk_in);
    rdy_after = ready;
    th_after  = theta;
    for (int i = 1; i < hold; i++) @(negedge clk_in);
    finish = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  // Full transaction with all standard checks.
  task automatic run_txn(input string name, input logic pn, input int req_cycles, input int fin_wait);
    int lat;
    logic early, ms, stable, rdy_after;
    logic [W-1:0] th, th_after, exp_th;
    exp_th = model_theta();
    do_measure(pn, req_cycles, lat, early, th, ms);
    do_finish(fin_wait, 1 + int'($urandom_range(0, 3)), stable, rdy_after, th_after);
    $display("txn %s pn=%0d lat=%0d theta=%h exp=%h", name, pn, lat, th, exp_th);
    checks++; if (lat !== 10) begin errors++; $display("FAIL %s latency: got %0d expected 10", name, lat); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL %s early_ready: got %b expected 0", name, early); end
    checks++; if (th !== exp_th) begin errors++; $display("FAIL %s theta: got %h expected %h", name, th, exp_th); end
    checks++; if (ms !== pn) begin errors++; $display("FAIL %s meas_sel: got %b expected %b", name, ms, pn); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL %s done_stable: got %b expected 1", name, stable); end
    checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL %s ready_after_finish: got %b expected 0", name, rdy_after); end
    checks++; if (th_after !== exp_th) begin errors++; $display("FAIL %s theta_after_finish: got %h expected %h", name, th_after, exp_th); end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (theta !== '0) begin errors++; $display("FAIL reset_theta: got %h expected 0", theta); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (meas_sel !== 1'b0) begin errors++; $display("FAIL reset_meas_sel: got %b expected 0", meas_sel); end
    rstn = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) samp[i] = 20'h000FF;
    run_txn("basic", 1'b0, 4, 3);
  endtask

  task automatic test_bubble();
    for (int i = 0; i < N; i++) samp[i] = (i % 2 == 0) ? 20'h0007F : 20'h001FF;
    run_txn("bubble_free", 1'b0, 2, 1);
    samp[2] = 20'h000F7;
    run_txn("bubble", 1'b0, 1, 0);
  endtask

  task automatic test_rounding();
    for (int i = 0; i < N; i++) samp[i] = (i < 4) ? 20'h0001F : 20'h0003F;
    run_txn("round_44", 1'b0, 1, 2);
    for (int i = 0; i < N; i++) samp[i] = (i == 5) ? 20'h0003F : 20'h0001F;
    run_txn("round_41", 1'b0, 3, 0);
  endtask

  task automatic test_phase();
    for (int i = 0; i < N; i++) samp[i] = 20'hFFFFF;
    run_txn("phase_neg", 1'b1, 4, 1);
    for (int i = 0; i < N; i++) samp[i] = 20'h00000;
    run_txn("phase_pos_zero", 1'b0, 4, 1);
  endtask

  task automatic test_done_ignore();
    int lat;
    logic early, ms, ok, quiet;
    logic [W-1:0] th, exp_th;
    for (int i = 0; i < N; i++) samp[i] = 20'h003FF;
    exp_th = model_theta();
    do_measure(1'b0, 2, lat, early, th, ms);
    checks++; if (th !== exp_th) begin errors++; $display("FAIL done_ignore theta: got %h expected %h", th, exp_th); end
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      drive_junk();
      request = (i == 1 || i == 2);
      pos_neg = 1'b1;
      if (!ready || theta !== exp_th) ok = 1'b0;
    end
    request = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL done_ignore hold: got %b expected 1", ok); end
    finish = 1'b1;
    @(negedge clk_in);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL done_ignore ready_drop: got %b expected 0", ready); end
    finish = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      drive_junk();
      if (ready || theta !== exp_th) quiet = 1'b0;
    end
    $display("txn done_ignore theta=%h quiet=%b", th, quiet);
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL done_ignore no_new_txn: got %b expected 1", quiet); end
    for (int i = 0; i < N; i++) samp[i] = 20'h0000F;
    run_txn("after_done_ignore", 1'b0, 1, 0);
  endtask

  task automatic test_finish_early();
    int lat;
    logic early, ms;
    logic [W-1:0] th, exp_th;
    for (int i = 0; i < N; i++) samp[i] = 20'h00FFF;
    exp_th = model_theta();
    finish = 1'b1;
    do_measure(1'b1, 2, lat, early, th, ms);
    checks++; if (lat !== 10) begin errors++; $display("FAIL finish_early latency: got %0d expected 10", lat); end
    checks++; if (th !== exp_th) begin errors++; $display("FAIL finish_early theta: got %h expected %h", th, exp_th); end
    @(negedge clk_in);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL finish_early ready_drop: got %b expected 0", ready); end
    repeat (3) @(negedge clk_in);
    checks++; if (ready !== 1'b0 || theta !== exp_th) begin errors++; $display("FAIL finish_early rel_hold: got ready=%b theta=%h expected ready=0 theta=%h", ready, theta, exp_th); end
    finish = 1'b0;
    repeat (2) @(negedge clk_in);
    $display("txn finish_early lat=%0d theta=%h", lat, th);
  endtask

  task automatic test_reset_mid();
    cur_pn = 1'b1;
    for (int i = 0; i < N; i++) samp[i] = 20'hFFFFF;
    @(negedge clk_in);
    request = 1'b1;
    pos_neg = 1'b1;
    @(negedge clk_in);
    request = 1'b0;
    drive_sample(0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk_in);
      drive_sample(k);
    end
    checks++; if (meas_sel !== 1'b1) begin errors++; $display("FAIL reset_mid pre_meas_sel: got %b expected 1", meas_sel); end
    rstn = 1'b0;
    @(negedge clk_in);
    rstn = 1'b1;
    $display("txn reset_mid theta=%h ready=%b meas_sel=%b", theta, ready, meas_sel);
    checks++; if (theta !== '0) begin errors++; $display("FAIL reset_mid theta: got %h expected 0", theta); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_mid ready: got %b expected 0", ready); end
    checks++; if (meas_sel !== 1'b0) begin errors++; $display("FAIL reset_mid meas_sel: got %b expected 0", meas_sel); end
    for (int i = 0; i < N; i++) samp[i] = 20'h00007;
    run_txn("after_reset_mid", 1'b0, 1, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [W-1:0] mask;
      int len;
      len  = int'($urandom_range(0, W));
      mask = W'((1 << len) - 1);
      for (int i = 0; i < N; i++) begin
        samp[i] = ($urandom_range(0, 3) == 0) ? (W'($urandom) & mask) : mask;
        if ($urandom_range(0, 4) == 0) samp[i] = W'($urandom);
      end
      run_txn($sformatf("rand%0d", t), 1'($urandom), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_rounding();
    test_phase();
    test_done_ignore();
    test_finish_early();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
